// File: rtl/mem_rd_pkg.sv
// Shared constants, FSM encoding and small helpers for the memory read command engine.
package mem_rd_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int PAGE_BYTES = 4096;
    localparam int BEAT_CNT_W = 27;   // ceil((2^32-1)/64) beats fits in 27 bits

    localparam int STS_ERR_BIT  = 0;
    localparam int STS_ZERO_BIT = 1;
    localparam int STS_DONE_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STATUS
    } state_t;

    function automatic logic [BEAT_BYTES-1:0] keep_mask(input logic [5:0] tail);
        logic [BEAT_BYTES-1:0] m;
        if (tail == 6'd0) m = '1;
        else              m = (64'd1 << tail) - 64'd1;
        return m;
    endfunction

    function automatic logic [6:0] tail_bytes(input logic [5:0] tail);
        return (tail == 6'd0) ? 7'd64 : {1'b0, tail};
    endfunction

    function automatic logic [7:0] sts_byte(input logic err, input logic zero);
        logic [7:0] b;
        b               = '0;
        b[STS_DONE_BIT] = 1'b1;
        b[STS_ERR_BIT]  = err;
        b[STS_ZERO_BIT] = zero;
        return b;
    endfunction

endpackage

// File: rtl/mem_rd_burst_calc.sv
// Burst sizing: beats = min(remaining, beats left in the 4 KB page, MAX_BURST_BEATS).
module mem_rd_burst_calc
    import mem_rd_pkg::*;
#(
    parameter int MAX_BURST_BEATS = 64
) (
    input  logic [5:0]            page_idx,   // address bits [11:6]
    input  logic [BEAT_CNT_W-1:0] remaining,
    output logic [8:0]            beats,
    output logic [7:0]            arlen
);

    localparam logic [8:0] MAX_B = 9'(MAX_BURST_BEATS);

    logic [6:0] page_beats;
    logic [8:0] cap;

    always_comb begin
        page_beats = 7'd64 - {1'b0, page_idx};
        cap        = ({2'b00, page_beats} > MAX_B) ? MAX_B : {2'b00, page_beats};
        beats      = (remaining < {{(BEAT_CNT_W-9){1'b0}}, cap}) ? remaining[8:0] : cap;
        arlen      = 8'(beats - 9'd1);
    end

endmodule

// File: rtl/mem_cmd_rd_engine.sv
// Splits read commands into 4 KB-safe AXI4 bursts and streams the data back with TLAST/TKEEP.
// Optional per-command cycle/byte counters are built when MEM_RD_PERF_CNT_EN is defined.
module mem_cmd_rd_engine
    import mem_rd_pkg::*;
#(
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST_BEATS = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    input  logic [63:0]             s_cmd_address,
    input  logic [31:0]             s_cmd_length,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [5:0]              m_axi_arid,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic [DATA_WIDTH/8-1:0] m_axis_keep,
    output logic                    m_axis_last,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic                    m_sts_valid,
    input  logic                    m_sts_ready,
    output logic [7:0]              m_sts_data,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_bytes
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_t                state_reg;
    logic                  cmd_ready_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [BEAT_CNT_W-1:0] total_beats_reg;
    logic [BEAT_CNT_W-1:0] remaining_reg;
    logic [BEAT_CNT_W-1:0] rx_beats_reg;
    logic [5:0]            tail_reg;
    logic [OUT_W-1:0]      outstanding_reg;
    logic                  arvalid_reg;
    logic [ADDR_WIDTH-1:0] araddr_reg;
    logic [7:0]            arlen_reg;
    logic [8:0]            ar_beats_reg;
    logic                  err_reg;
    logic                  sts_valid_reg;
    logic [7:0]            sts_data_reg;

    logic [8:0]            calc_beats;
    logic [7:0]            calc_arlen;
    logic [BEAT_CNT_W-1:0] cmd_beats;
    logic                  cmd_hs, ar_hs, r_hs, run, rx_final, r_err;
    logic                  unused_addr_bits;

    assign cmd_hs    = s_cmd_valid && cmd_ready_reg;
    assign ar_hs     = arvalid_reg && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign run       = (state_reg == ST_RUN);
    assign rx_final  = (rx_beats_reg == total_beats_reg - 1'b1);
    assign r_err     = (m_axi_rresp != 2'b00);
    assign cmd_beats = {1'b0, s_cmd_length[31:6]} + BEAT_CNT_W'(|s_cmd_length[5:0]);
    assign unused_addr_bits = |s_cmd_address[63:ADDR_WIDTH];

    mem_rd_burst_calc #(
        .MAX_BURST_BEATS(MAX_BURST_BEATS)
    ) u_burst_calc (
        .page_idx (addr_reg[11:6]),
        .remaining(remaining_reg),
        .beats    (calc_beats),
        .arlen    (calc_arlen)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg       <= ST_IDLE;
            cmd_ready_reg   <= 1'b0;
            addr_reg        <= '0;
            total_beats_reg <= '0;
            remaining_reg   <= '0;
            rx_beats_reg    <= '0;
            tail_reg        <= '0;
            outstanding_reg <= '0;
            arvalid_reg     <= 1'b0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            ar_beats_reg    <= '0;
            err_reg         <= 1'b0;
            sts_valid_reg   <= 1'b0;
            sts_data_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready_reg   <= 1'b0;
                        addr_reg        <= s_cmd_address[ADDR_WIDTH-1:0];
                        total_beats_reg <= cmd_beats;
                        remaining_reg   <= cmd_beats;
                        tail_reg        <= s_cmd_length[5:0];
                        rx_beats_reg    <= '0;
                        outstanding_reg <= '0;
                        err_reg         <= 1'b0;
                        if (s_cmd_length == 32'd0) begin
                            state_reg     <= ST_STATUS;
                            sts_valid_reg <= 1'b1;
                            sts_data_reg  <= sts_byte(1'b0, 1'b1);
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Address/remaining advance at acceptance, so the calc stays stable while arvalid is held.
                    if (ar_hs) begin
                        arvalid_reg   <= 1'b0;
                        addr_reg      <= addr_reg + ADDR_WIDTH'({ar_beats_reg, 6'd0});
                        remaining_reg <= remaining_reg - BEAT_CNT_W'(ar_beats_reg);
                    end else if (!arvalid_reg && remaining_reg != '0 &&
                                 outstanding_reg < OUT_W'(MAX_OUTSTANDING)) begin
                        arvalid_reg  <= 1'b1;
                        araddr_reg   <= addr_reg;
                        arlen_reg    <= calc_arlen;
                        ar_beats_reg <= calc_beats;
                    end
                    case ({ar_hs, r_hs && m_axi_rlast})
                        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                        default: ;
                    endcase
                    if (r_hs) begin
                        rx_beats_reg <= rx_beats_reg + 1'b1;
                        if (r_err) err_reg <= 1'b1;
                        if (rx_final) begin
                            state_reg     <= ST_STATUS;
                            sts_valid_reg <= 1'b1;
                            sts_data_reg  <= sts_byte(err_reg || r_err, 1'b0);
                        end
                    end
                end
                ST_STATUS: begin
                    if (m_sts_ready) begin
                        sts_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign s_cmd_ready   = cmd_ready_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = arlen_reg;
    assign m_axi_arsize  = 3'd6;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = 6'd0;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = m_axis_ready && run;
    assign m_axis_valid  = m_axi_rvalid && run;
    assign m_axis_data   = m_axi_rdata;
    assign m_axis_last   = run && rx_final;
    assign m_axis_keep   = rx_final ? keep_mask(tail_reg) : '1;
    assign m_sts_valid   = sts_valid_reg;
    assign m_sts_data    = sts_data_reg;

`ifdef MEM_RD_PERF_CNT_EN
    logic [31:0] cyc_cnt_reg, byte_cnt_reg, perf_cycles_reg, perf_bytes_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cyc_cnt_reg     <= '0;
            byte_cnt_reg    <= '0;
            perf_cycles_reg <= '0;
            perf_bytes_reg  <= '0;
        end else begin
            if (cmd_hs)                      cyc_cnt_reg <= '0;
            else if (state_reg != ST_IDLE)   cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
            if (cmd_hs)                      byte_cnt_reg <= '0;
            else if (r_hs)
                byte_cnt_reg <= byte_cnt_reg + (rx_final ? 32'(tail_bytes(tail_reg)) : 32'd64);
            if (state_reg == ST_STATUS && m_sts_ready) begin
                perf_cycles_reg <= cyc_cnt_reg + 32'd1;
                perf_bytes_reg  <= byte_cnt_reg;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_bytes  = perf_bytes_reg;
`else
    assign perf_cycles = 32'd0;
    assign perf_bytes  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_cmd_rd_engine.sv
// Directed bench for mem_cmd_rd_engine: an AXI slave/stream sink model plus one task per scenario.
module tb_mem_cmd_rd_engine;

    logic         aclk;
    logic         aresetn;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [63:0]  s_cmd_address;
    logic [31:0]  s_cmd_length;
    logic [32:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic [5:0]   m_axi_arid;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] m_axis_data;
    logic [63:0]  m_axis_keep;
    logic         m_axis_last;
    logic         m_axis_valid;
    logic         m_axis_ready;
    logic         m_sts_valid;
    logic         m_sts_ready;
    logic [7:0]   m_sts_data;
    logic [31:0]  perf_cycles;
    logic [31:0]  perf_bytes;

    int errors = 0;
    int checks = 0;

    // Scenario knobs, written only by the main sequence.
    bit ar_stall = 0;
    bit r_gap    = 0;
    bit bp       = 0;
    int err_beat = -1;

    // Slave/sink model state, written only by the bus process.
    int           bq[$];
    int           head_pos;
    int           r_beat_cnt;
    bit           r_hold;
    int           tb_out;
    int           tb_out_max;
    int           ar_attr_bad;
    logic [32:0]  ar_addr_q[$];
    int           ar_len_q[$];
    logic [511:0] st_data_q[$];
    logic [63:0]  st_keep_q[$];
    bit           st_last_q[$];

    mem_cmd_rd_engine #(
        .ADDR_WIDTH     (33),
        .DATA_WIDTH     (512),
        .MAX_BURST_BEATS(64),
        .MAX_OUTSTANDING(2)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_cmd_address(s_cmd_address),
        .s_cmd_length (s_cmd_length),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arid   (m_axi_arid),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axis_data  (m_axis_data),
        .m_axis_keep  (m_axis_keep),
        .m_axis_last  (m_axis_last),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_sts_valid  (m_sts_valid),
        .m_sts_ready  (m_sts_ready),
        .m_sts_data   (m_sts_data),
        .perf_cycles  (perf_cycles),
        .perf_bytes   (perf_bytes)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // AXI read slave + stream sink: drive at negedge, record handshakes 1 ns later.
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axis_ready  = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axis_ready  = 1'b0;
                bq.delete();
                head_pos = 0;
                r_hold   = 0;
                tb_out   = 0;
                continue;
            end
            m_axi_arready = ar_stall ? ($urandom_range(0, 3) == 0) : 1'b1;
            if (!r_hold)
                m_axi_rvalid = (bq.size() > 0) && (!r_gap || $urandom_range(0, 1) == 1);
            if (bq.size() > 0) begin
                m_axi_rdata = {16{32'(r_beat_cnt)}};
                m_axi_rresp = (r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (head_pos == bq[0] - 1);
            end
            m_axis_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (s_cmd_valid && s_cmd_ready) begin
                ar_addr_q.delete();
                ar_len_q.delete();
                st_data_q.delete();
                st_keep_q.delete();
                st_last_q.delete();
                r_beat_cnt  = 0;
                tb_out_max  = 0;
                ar_attr_bad = 0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(int'(m_axi_arlen));
                bq.push_back(int'(m_axi_arlen) + 1);
                tb_out++;
                if (m_axi_arsize !== 3'd6 || m_axi_arburst !== 2'b01 || m_axi_arid !== 6'd0)
                    ar_attr_bad++;
            end
            if (m_axis_valid && m_axis_ready) begin
                st_data_q.push_back(m_axis_data);
                st_keep_q.push_back(m_axis_keep);
                st_last_q.push_back(m_axis_last);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                r_hold = 0;
                r_beat_cnt++;
                if (m_axi_rlast) begin
                    void'(bq.pop_front());
                    head_pos = 0;
                    tb_out--;
                end else begin
                    head_pos++;
                end
            end else begin
                r_hold = m_axi_rvalid;
            end
            if (tb_out > tb_out_max) tb_out_max = tb_out;
        end
    end

    // Issue one command, then take its status; sts_wait is the number of negedges waited after accept.
    task automatic run_cmd(input logic [63:0] a, input logic [31:0] l,
                           output logic [7:0] sts, output int sts_wait);
        int n;
        @(negedge aclk);
        s_cmd_valid   = 1'b1;
        s_cmd_address = a;
        s_cmd_length  = l;
        #1;
        n = 0;
        while (!s_cmd_ready && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL cmd_accept: s_cmd_ready=%0b after %0d cycles, required 1", s_cmd_ready, n);
        end
        @(negedge aclk);
        s_cmd_valid = 1'b0;
        n = 0;
        while (!m_sts_valid && n < 20000) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (!m_sts_valid) begin
            errors++;
            $display("FAIL sts_timeout: m_sts_valid=0 after %0d cycles, required 1", n);
        end
        sts_wait    = n;
        sts         = m_sts_data;
        m_sts_ready = 1'b1;
        @(negedge aclk);
        m_sts_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++;
        if (s_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_cmd_ready: got %0b required 0", s_cmd_ready);
        end
        checks++;
        if (m_axi_arvalid !== 1'b0 || m_sts_valid !== 1'b0 || m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valids: arvalid=%0b sts_valid=%0b axis_valid=%0b required 0/0/0",
                     m_axi_arvalid, m_sts_valid, m_axis_valid);
        end
        checks++;
        if (perf_cycles !== 32'd0 || perf_bytes !== 32'd0) begin
            errors++;
            $display("FAIL rst_perf: cycles=%0d bytes=%0d required 0/0", perf_cycles, perf_bytes);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (s_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_ready: got %0b required 1", s_cmd_ready);
        end
    endtask

    task automatic test_single_burst();
        logic [7:0] sts;
        int w;
        ar_stall = 0; r_gap = 0; bp = 0; err_beat = -1;
        run_cmd(64'h1000, 32'd256, sts, w);
        checks++;
        if (ar_addr_q.size() != 1) begin
            errors++;
            $display("FAIL single_ar_count: got %0d required 1", ar_addr_q.size());
        end else begin
            checks++;
            if (ar_addr_q[0] !== 33'h1000 || ar_len_q[0] != 3) begin
                errors++;
                $display("FAIL single_ar: araddr=%h arlen=%0d required 1000/3", ar_addr_q[0], ar_len_q[0]);
            end
        end
        checks++;
        if (ar_attr_bad != 0) begin
            errors++;
            $display("FAIL ar_attr: %0d bursts with wrong arsize/arburst/arid, required 0", ar_attr_bad);
        end
        checks++;
        if (st_data_q.size() != 4) begin
            errors++;
            $display("FAIL single_beats: got %0d required 4", st_data_q.size());
        end
        for (int i = 0; i < st_data_q.size(); i++) begin
            checks++;
            if (st_data_q[i] !== {16{32'(i)}} || st_keep_q[i] !== 64'hFFFF_FFFF_FFFF_FFFF ||
                st_last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL single_beat%0d: data[31:0]=%h keep=%h last=%0b required %h/all-ones/%0b",
                         i, st_data_q[i][31:0], st_keep_q[i], st_last_q[i], i, (i == 3));
            end
        end
        checks++;
        if (sts !== 8'h80) begin
            errors++;
            $display("FAIL single_sts: got %h required 80", sts);
        end
    endtask

    task automatic test_page_split();
        logic [7:0] sts;
        int w;
        ar_stall = 0; r_gap = 0; bp = 0; err_beat = -1;
        run_cmd(64'h0FC0, 32'd128, sts, w);
        checks++;
        if (ar_addr_q.size() != 2) begin
            errors++;
            $display("FAIL split_ar_count: got %0d required 2", ar_addr_q.size());
        end else begin
            checks++;
            if (ar_addr_q[0] !== 33'h0FC0 || ar_len_q[0] != 0 ||
                ar_addr_q[1] !== 33'h1000 || ar_len_q[1] != 0) begin
                errors++;
                $display("FAIL split_ar: %h/%0d %h/%0d required 0fc0/0 1000/0",
                         ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
            end
        end
        checks++;
        if (st_data_q.size() != 2 || st_last_q[st_last_q.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL split_beats: got %0d beats required 2 ending in last", st_data_q.size());
        end
        checks++;
        if (sts !== 8'h80) begin
            errors++;
            $display("FAIL split_sts: got %h required 80", sts);
        end
    endtask

    task automatic test_partial_tail();
        logic [7:0] sts;
        int w;
        ar_stall = 0; r_gap = 0; bp = 0; err_beat = -1;
        run_cmd(64'h0, 32'd100, sts, w);
        checks++;
        if (ar_len_q.size() != 1 || ar_len_q[0] != 1) begin
            errors++;
            $display("FAIL tail_ar: count=%0d required 1 burst of arlen 1", ar_len_q.size());
        end
        checks++;
        if (st_data_q.size() != 2) begin
            errors++;
            $display("FAIL tail_beats: got %0d required 2", st_data_q.size());
        end else begin
            checks++;
            if (st_keep_q[0] !== 64'hFFFF_FFFF_FFFF_FFFF || st_last_q[0] !== 1'b0) begin
                errors++;
                $display("FAIL tail_beat0: keep=%h last=%0b required all-ones/0", st_keep_q[0], st_last_q[0]);
            end
            checks++;
            if (st_keep_q[1] !== 64'h0000_000F_FFFF_FFFF || st_last_q[1] !== 1'b1) begin
                errors++;
                $display("FAIL tail_beat1: keep=%h last=%0b required 0000000fffffffff/1",
                         st_keep_q[1], st_last_q[1]);
            end
        end
        checks++;
        if (sts !== 8'h80) begin
            errors++;
            $display("FAIL tail_sts: got %h required 80", sts);
        end
    endtask

    task automatic test_zero_length();
        logic [7:0] sts;
        int w;
        ar_stall = 0; r_gap = 0; bp = 0; err_beat = -1;
        run_cmd(64'h4000, 32'd0, sts, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL zero_latency: status after %0d extra cycles, required 0", w);
        end
        checks++;
        if (sts !== 8'h82) begin
            errors++;
            $display("FAIL zero_sts: got %h required 82", sts);
        end
        checks++;
        if (ar_addr_q.size() != 0 || st_data_q.size() != 0) begin
            errors++;
            $display("FAIL zero_traffic: ars=%0d beats=%0d required 0/0", ar_addr_q.size(), st_data_q.size());
        end
    endtask

    task automatic test_max_outstanding();
        logic [7:0] sts;
        int w;
        int bad;
        ar_stall = 1; r_gap = 1; bp = 1; err_beat = -1;
        run_cmd(64'h0, 32'd65536, sts, w);
        checks++;
        if (tb_out_max != 2) begin
            errors++;
            $display("FAIL max_outstanding: peak %0d required 2", tb_out_max);
        end
        checks++;
        if (ar_addr_q.size() != 16) begin
            errors++;
            $display("FAIL big_ar_count: got %0d required 16", ar_addr_q.size());
        end
        for (int i = 0; i < ar_addr_q.size(); i++) begin
            checks++;
            if (ar_addr_q[i] !== 33'(i * 4096) || ar_len_q[i] != 63) begin
                errors++;
                $display("FAIL big_ar%0d: %h/%0d required %h/63", i, ar_addr_q[i], ar_len_q[i], i * 4096);
            end
        end
        checks++;
        if (st_data_q.size() != 1024) begin
            errors++;
            $display("FAIL big_beats: got %0d required 1024", st_data_q.size());
        end
        bad = 0;
        for (int i = 0; i < st_data_q.size(); i++)
            if (st_data_q[i] !== {16{32'(i)}} || st_last_q[i] !== (i == 1023)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL big_stream: %0d beats out of order or wrong last, required 0", bad);
        end
        checks++;
        if (sts !== 8'h80) begin
            errors++;
            $display("FAIL big_sts: got %h required 80", sts);
        end
    endtask

    task automatic test_resp_error();
        logic [7:0] sts;
        int w;
        ar_stall = 0; r_gap = 1; bp = 1; err_beat = 1;
        run_cmd(64'h2000, 32'd256, sts, w);
        checks++;
        if (st_data_q.size() != 4) begin
            errors++;
            $display("FAIL err_beats: got %0d required 4", st_data_q.size());
        end
        for (int i = 0; i < st_data_q.size(); i++) begin
            checks++;
            if (st_data_q[i] !== {16{32'(i)}} || st_last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL err_beat%0d: data[31:0]=%h last=%0b required %h/%0b",
                         i, st_data_q[i][31:0], st_last_q[i], i, (i == 3));
            end
        end
        checks++;
        if (sts !== 8'h81) begin
            errors++;
            $display("FAIL err_sts: got %h required 81", sts);
        end
        err_beat = -1;
    endtask

    task automatic test_reset_mid_cmd();
        int n;
        ar_stall = 1; r_gap = 1; bp = 1; err_beat = -1;
        @(negedge aclk);
        s_cmd_valid   = 1'b1;
        s_cmd_address = 64'h0;
        s_cmd_length  = 32'd65536;
        #1;
        n = 0;
        while (!s_cmd_ready && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        @(negedge aclk);
        s_cmd_valid = 1'b0;
        repeat (40) @(negedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (s_cmd_ready !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axis_valid !== 1'b0 || m_sts_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: cmd_ready=%0b arvalid=%0b axis_valid=%0b sts_valid=%0b required all 0",
                     s_cmd_ready, m_axi_arvalid, m_axis_valid, m_sts_valid);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sts_a, sts_b;
        int w;
        ar_stall = 0; r_gap = 0; bp = 1; err_beat = -1;
        run_cmd(64'h3000, 32'd64, sts_a, w);
        checks++;
        if (sts_a !== 8'h80 || ar_len_q.size() != 1 || st_last_q.size() != 1 ||
            st_keep_q[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_first: sts=%h ars=%0d beats=%0d required 80/1/1 full keep",
                     sts_a, ar_len_q.size(), st_last_q.size());
        end
        run_cmd(64'h5040, 32'd4136, sts_b, w);
        checks++;
        if (ar_addr_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_ar_count: got %0d required 2", ar_addr_q.size());
        end else begin
            checks++;
            if (ar_addr_q[0] !== 33'h5040 || ar_len_q[0] != 62 ||
                ar_addr_q[1] !== 33'h6000 || ar_len_q[1] != 1) begin
                errors++;
                $display("FAIL b2b_ar: %h/%0d %h/%0d required 5040/62 6000/1",
                         ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
            end
        end
        checks++;
        if (st_data_q.size() != 65) begin
            errors++;
            $display("FAIL b2b_beats: got %0d required 65", st_data_q.size());
        end else begin
            checks++;
            if (st_keep_q[64] !== 64'h0000_00FF_FFFF_FFFF || st_last_q[64] !== 1'b1 || st_last_q[63] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_tail: keep=%h last=%0b required 000000ffffffffff/1",
                         st_keep_q[64], st_last_q[64]);
            end
        end
        checks++;
        if (sts_b !== 8'h80) begin
            errors++;
            $display("FAIL b2b_sts: got %h required 80", sts_b);
        end
    endtask

    initial begin
        aresetn       = 1'b1;
        s_cmd_valid   = 1'b0;
        s_cmd_address = '0;
        s_cmd_length  = '0;
        m_sts_ready   = 1'b0;
        #2;
        aresetn = 1'b0;
        test_reset();
        test_single_burst();
        $display("single_burst done: checks=%0d errors=%0d", checks, errors);
        test_page_split();
        $display("page_split done: checks=%0d errors=%0d", checks, errors);
        test_partial_tail();
        $display("partial_tail done: checks=%0d errors=%0d", checks, errors);
        test_zero_length();
        $display("zero_length done: checks=%0d errors=%0d", checks, errors);
        test_max_outstanding();
        $display("max_outstanding done: checks=%0d errors=%0d", checks, errors);
        test_resp_error();
        $display("resp_error done: checks=%0d errors=%0d", checks, errors);
        test_reset_mid_cmd();
        $display("reset_mid_cmd done: checks=%0d errors=%0d", checks, errors);
        test_back_to_back();
        $display("back_to_back done: checks=%0d errors=%0d", checks, errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_cmd_rd_engine.md
Name: mem_cmd_rd_engine

Overview:
- Consumes read commands (64-bit address, 32-bit byte length) from the DMA/TCP control logic on an axis_mem_cmd-style handshake.
- Splits each command into AXI4 read bursts that never cross a 4 KB boundary and never exceed MAX_BURST_BEATS.
- Returns the read data as a 512-bit AXI stream with TLAST and TKEEP set for the whole command.
- Posts one axis_mem_status byte per command; sits directly between command generation and the axi_mm DDR/HBM port.

Parameters:
ADDR_WIDTH, 33, AXI araddr width; command address is truncated to this width
DATA_WIDTH, 512, AXI rdata and stream width; fixed 64 B beat
MAX_BURST_BEATS, 64, maximum beats per AR burst (1..256)
MAX_OUTSTANDING, 8, maximum AR bursts issued but not yet fully returned

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_cmd_valid/s_cmd_ready  in/out  1/1  command handshake
s_cmd_address  in  64  byte address; bits [5:0] must be 0
s_cmd_length  in  32  byte count
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen/arsize/arburst/arid  out  8/3/2/6  arsize=6, arburst=INCR, arid=0
m_axi_arvalid/arready  out/in  1/1  AR handshake
m_axi_rdata/rresp/rlast  in  DATA_WIDTH/2/1  R channel
m_axi_rvalid/rready  in/out  1/1  R handshake
m_axis_data/keep/last  out  DATA_WIDTH/DATA_WIDTH/8/1  output stream
m_axis_valid/ready  out/in  1/1  stream handshake
m_sts_valid/ready/data  out/in/out  1/1/8  status
perf_cycles/perf_bytes  out  32/32  last-command counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE. s_cmd_ready=0 while reset is asserted; all valid outputs and counters are 0.
- FSM states:
  - IDLE: s_cmd_ready=1. On handshake, latch addr, total_beats=ceil(len/64) and tail=len[5:0]. If len==0 -> STATUS, else -> RUN.
  - RUN: the AR issuer and R receiver run concurrently. Go to STATUS on the handshaked beat where rx_beats==total_beats-1.
  - STATUS: assert m_sts_valid; data bit0=resp error (any rresp!=0 during the command), bit1=zero-length, bit7=done(1), others 0. Return to IDLE on m_sts_ready.
- Burst size: beats = min(remaining_beats, (4096-addr[11:0])>>6, MAX_BURST_BEATS); arlen=beats-1.
- AR issuer:
  - arvalid is registered and stays stable until arready.
  - On handshake: addr+=beats*64, remaining-=beats, outstanding++.
  - No new arvalid while outstanding==MAX_OUTSTANDING.
- Outstanding counter: decrements on the R beat with rlast handshaked. Simultaneous AR handshake and rlast leave it unchanged.
- R path (combinational pass-through, zero latency):
  - m_axis_valid=rvalid&&state==RUN; rready=m_axis_ready&&state==RUN; data=rdata.
  - last=1 only on the command's final beat; keep there = tail==0 ? all ones : (1<<tail)-1; otherwise all ones.
  - rlast is used for counting only.
- An rresp error does not abort the command; all beats are still drained.
- s_cmd_address[63:ADDR_WIDTH] is ignored.
- Reset mid-command: all state clears immediately; in-flight AXI responses are the interconnect's responsibility (it is reset together with this block).

Optional Feature:
MEM_RD_PERF_CNT_EN:
- Defined: perf_cycles counts aclk cycles from cmd accept to status handshake, perf_bytes counts bytes delivered (keep popcount sum); both are captured at STATUS exit and hold until the next capture.
- Undefined: both ports are tied to 0 and no counters are synthesised.

Decomposition:
- Package mem_rd_pkg: BEAT_BYTES=64, PAGE_BYTES=4096, state enum, status bit positions, keep-mask function.
- One sub-module, mem_rd_burst_calc: combinational min() of remaining/page/max beats, producing beats and arlen. Easy to unit-test separately.

Test Plan:
- addr=0x1000, len=256 -> one AR (araddr 0x1000, arlen 3); 4 stream beats; last on beat 4 with keep all-ones; status 0x80.
- addr=0x0FC0, len=128 -> two ARs: 0x0FC0/arlen 0 and 0x1000/arlen 0 (4 KB split); status 0x80.
- addr=0, len=100 -> arlen 1; final beat keep=0x0000000FFFFFFFFF (36 B); last=1.
- len=0 -> no arvalid; status 0x82 next cycle after accept.
- len=64 KB with MAX_OUTSTANDING=2 and slave arready stalled -> never more than 2 outstanding bursts; 16 ARs of arlen 63; 1024 beats delivered.
- rresp=SLVERR on beat 2 of 4 -> all 4 beats forwarded; status 0x81. Random m_axis_ready backpressure loses no beats.
